uart_tx_stage: RTL and testbench

Downstream output stage of the tt_um_k_ziegler27 top. It accepts bytes from the core over a valid/ready handshake and buffers them in a small FIFO. Each byte is serialized as an 8N1 UART frame on one dedicated output pin (uo_out[0]). Status bits go to spare uo_out pins for bench and board observation.

---
 rtl/uart_tx_pkg.sv | 16 +
 rtl/uart_tx_stage_fifo.sv | 76 +++++++
 rtl/uart_tx_stage.sv | 158 +++++++++++++++
 tb/tb_uart_tx_stage.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit output stage.
package uart_tx_pkg;

    // Transmit FSM states, one per portion of an 8N1 frame.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam int   DATA_BITS  = 8;
    localparam int   STOP_BITS  = 1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_stage_fifo.sv
// Small synchronous FIFO with count, full/empty and a sticky overflow flag.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     push_valid,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]            count_q, count_d;
    logic                        overflow_q, overflow_d;
    logic                        push_en, pop_en;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;
    assign pop_data = mem_q[rd_ptr_q];

    // A push into a full FIFO is dropped and latched as overflow instead.
    assign push_en = push_valid & ~full;
    assign pop_en  = pop & ~empty;

    // Next-state for storage, pointers (natural wrap) and occupancy.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (push_valid & full);
        if (push_en) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO state registers; reset empties the FIFO and clears overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

endmodule

// File: rtl/uart_tx_stage.sv
// UART 8N1 transmitter fed from a byte FIFO over a valid/ready handshake.
module uart_tx_stage
    import uart_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       overflow
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    // frame_done is registered, so it is raised one cycle before the
    // final stop-bit cycle to be visible during that cycle.
    localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    tx_state_e          state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               done_q, done_d;

    logic [7:0]         fifo_head;
    logic [CNT_W-1:0]   fifo_count;
    logic               fifo_full, fifo_empty, fifo_pop;
    logic               bit_end;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push_data  (in_data),
        .push_valid (in_valid),
        .pop        (fifo_pop),
        .pop_data   (fifo_head),
        .count      (fifo_count),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .overflow   (overflow)
    );

    assign in_ready   = ~fifo_full;
    assign tx         = tx_q;
    assign frame_done = done_q;
    assign busy       = (state_q != IDLE) | (fifo_count != '0);
    assign bit_end    = (baud_q == BAUD_LAST);

    // Frame sequencing: next state, baud/bit counters, shifter and tx level.
    always_comb begin
        state_d  = state_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        done_d   = 1'b0;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                tx_d = IDLE_LEVEL;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = '0;
                    state_d  = START;
                    tx_d     = ~IDLE_LEVEL;
                end
            end
            START: begin
                if (bit_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = DATA;
                    tx_d    = shift_q[0];
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        state_d = STOP;
                        tx_d    = IDLE_LEVEL;
                    end else begin
                        bit_d = bit_q + BIT_W'(1);
                        tx_d  = shift_q[1];
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            STOP: begin
                done_d = (baud_q == BAUD_PRE) && (bit_q == STOP_LAST);
                if (bit_end) begin
                    baud_d = '0;
                    if (bit_q != STOP_LAST) begin
                        bit_d = bit_q + BIT_W'(1);
                    end else if (!fifo_empty) begin
                        // Back-to-back: straight into the next start bit.
                        fifo_pop = 1'b1;
                        shift_d  = fifo_head;
                        bit_d    = '0;
                        state_d  = START;
                        tx_d     = ~IDLE_LEVEL;
                    end else begin
                        bit_d   = '0;
                        state_d = IDLE;
                        tx_d    = IDLE_LEVEL;
                    end
                end else begin
                    baud_d = baud_q + BAUD_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = IDLE_LEVEL;
            end
        endcase
    end

    // FSM registers with registered tx and frame_done; reset aborts any frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= IDLE_LEVEL;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_stage.sv
// Self-checking bench: cycle-level frame-timeline reference plus line decoder.
module tb_uart_tx_stage;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FLEN  = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       frame_done;
    logic       overflow;

    uart_tx_stage #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference: queued bytes, position inside the current frame (-1 idle).
    logic [7:0] m_q[$];
    int         m_pos = -1;
    logic [7:0] m_cur = '0;
    bit         m_ovf = 1'b0;
    bit         m_acc = 1'b0;

    // Decoder working on the DUT tx line.
    logic [7:0] exp_q[$];
    int         d_pos = -1;
    logic [7:0] d_sh  = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Advance the reference by one clock edge using the inputs held there.
    task automatic model_edge();
        m_acc = 1'b0;
        if (rst) begin
            m_q.delete();
            exp_q.delete();
            m_pos = -1;
            m_ovf = 1'b0;
            d_pos = -1;
        end else begin
            m_acc = in_valid && (m_q.size() != DEPTH);
            if (in_valid && m_q.size() == DEPTH) m_ovf = 1'b1;
            if (m_q.size() != 0 && (m_pos < 0 || m_pos == FLEN - 1)) begin
                m_cur = m_q.pop_front();
                exp_q.push_back(m_cur);
                m_pos = 0;
            end else if (m_pos == FLEN - 1) begin
                m_pos = -1;
            end else if (m_pos >= 0) begin
                m_pos++;
            end
            if (m_acc) m_q.push_back(in_data);
        end
    endtask

    function automatic logic exp_tx();
        int b;
        if (m_pos < 0) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    task automatic check_outputs();
        chk("tx",         32'(tx),         32'(exp_tx()));
        chk("frame_done", 32'(frame_done), 32'(m_pos == FLEN - 1));
        chk("busy",       32'(busy),       32'(m_pos >= 0 || m_q.size() != 0));
        chk("in_ready",   32'(in_ready),   32'(m_q.size() != DEPTH));
        chk("overflow",   32'(overflow),   32'(m_ovf));
        // Decode the serial line by mid-bit sampling.
        if (d_pos < 0) begin
            if (tx === 1'b0) d_pos = 0;
        end else begin
            d_pos++;
        end
        if (d_pos == CPB / 2) chk("start_bit", 32'(tx), 32'(0));
        if (d_pos >= CPB && d_pos < 9 * CPB && (d_pos % CPB) == CPB / 2)
            d_sh = {tx, d_sh[7:1]};
        if (d_pos == 9 * CPB + CPB / 2) begin
            chk("stop_bit", 32'(tx), 32'(1));
            chk("exp_pending", 32'(exp_q.size()), 32'(1));
            if (exp_q.size() != 0) chk("byte", 32'(d_sh), 32'(exp_q.pop_front()));
        end
        if (d_pos == FLEN - 1) d_pos = -1;
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Present a byte and hold it until accepted (bounded); leaves in_valid high.
    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (m_acc) break;
        end
        chk("push_accept", 32'(m_acc), 32'(1));
    endtask

    task automatic drain();
        in_valid = 1'b0;
        for (int i = 0; i < 20 * FLEN; i++) begin
            if (m_pos < 0 && m_q.size() == 0) break;
            step();
        end
        chk("drain", 32'(m_pos < 0 && m_q.size() == 0), 32'(1));
    endtask

    task automatic wait_pos(input int p);
        for (int i = 0; i < 20 * FLEN; i++) begin
            if (m_pos == p) break;
            step();
        end
        chk("wait_pos", 32'(m_pos), 32'(p));
    endtask

    logic [7:0] burst[5] = '{8'h00, 8'hFF, 8'h3C, 8'h81, 8'h55};

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        idle(3);
        rst = 1'b0;
        idle(50);

        // Single frame.
        push_byte(8'hA5);
        in_valid = 1'b0;
        idle(FLEN + 8);

        // Back-to-back burst, fifth byte waits for the first pop.
        foreach (burst[i]) push_byte(burst[i]);
        drain();

        // Fill FIFO then keep presenting: overflow becomes sticky.
        for (int i = 0; i < 5; i++) push_byte(8'hC0 + 8'(i));
        in_data = 8'hEE;
        idle(5);
        in_valid = 1'b0;
        chk("overflow_set", 32'(overflow), 32'(1));
        drain();
        chk("overflow_hold", 32'(overflow), 32'(1));

        // Reset during data bit 3 with two bytes queued.
        push_byte(8'h96);
        push_byte(8'h11);
        push_byte(8'h22);
        in_valid = 1'b0;
        wait_pos(CPB * 4 + 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_tx",   32'(tx),       32'(1));
        chk("rst_busy", 32'(busy),     32'(0));
        chk("rst_ovf",  32'(overflow), 32'(0));
        idle(3 * FLEN);

        // Push on the same edge as the stop-to-start pop with two queued.
        push_byte(8'h40);
        push_byte(8'h41);
        push_byte(8'h42);
        in_valid = 1'b0;
        wait_pos(FLEN - 1);
        in_valid = 1'b1;
        in_data  = 8'h43;
        step();
        chk("same_edge_accept", 32'(m_acc), 32'(1));
        push_byte(8'h44);
        push_byte(8'h45);
        in_valid = 1'b0;
        step();
        chk("full_after_same_edge", 32'(in_ready), 32'(0));
        drain();

        // Pointer wrap with a 12-byte stream.
        for (int i = 1; i <= 12; i++) push_byte(8'(i));
        drain();

        // Random bytes with random gaps.
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b0;
            idle($urandom_range(0, 50));
            push_byte(8'($urandom));
        end
        drain();
        idle(4);
        chk("all_decoded", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
